// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives inst_mem, and buffers one fetched
// instruction toward decode through a valid/ready handshake. Supports redirects
// and halts when the PC leaves the populated ROM.
// Optional build macro FETCH_PERF_EN adds saturating fetch/stall counters.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned ROM_WORDS = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] inst_addr,
    input  logic [31:0] inst_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc_plus4,
    output logic        halted
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0] perf_fetch_cnt,
    output logic [15:0] perf_stall_cnt
`endif
);

    typedef enum logic [1:0] {StBoot, StFetch, StHalt} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] opc_q, opc_d;
    logic [31:0] opc4_q, opc4_d;

    logic [31:0] redirect_pc;
    logic        pc_in_rom;
    logic        tgt_in_rom;
    logic        capture;
    logic [1:0]  unused_tgt_lsb;

    // Word-index range check against the populated ROM.
    function automatic logic in_rom(input logic [29:0] word);
        return {2'b00, word} < ROM_WORDS;
    endfunction

    assign unused_tgt_lsb = redirect_target[1:0];
    assign redirect_pc    = {redirect_target[31:2], 2'b00};
    assign pc_in_rom      = in_rom(pc_q[31:2]);
    assign tgt_in_rom     = in_rom(redirect_target[31:2]);

    // Capture: fetching, no redirect, PC in range, and the buffer is free or draining.
    assign capture = (state_q == StFetch) && !redirect_valid && pc_in_rom
                     && (!valid_q || out_ready);

    // Next-state, PC and output-register update; redirect beats range check beats capture.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        instr_d = instr_q;
        opc_d   = opc_q;
        opc4_d  = opc4_q;
        case (state_q)
            StBoot: begin
                state_d = StFetch;
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                end
            end
            StFetch: begin
                if (redirect_valid) begin
                    // An out-of-range target is caught by the range check next cycle.
                    pc_d    = redirect_pc;
                    valid_d = 1'b0;
                end else if (!pc_in_rom) begin
                    state_d = StHalt;
                    if (out_ready) begin
                        valid_d = 1'b0;
                    end
                end else if (capture) begin
                    instr_d = inst_data;
                    opc_d   = pc_q;
                    opc4_d  = pc_q + 32'd4;
                    valid_d = 1'b1;
                    pc_d    = pc_q + 32'd4;
                end
            end
            StHalt: begin
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    valid_d = 1'b0;
                    if (tgt_in_rom) begin
                        state_d = StFetch;
                    end
                end else if (out_ready) begin
                    valid_d = 1'b0;
                end
            end
            default: state_d = StBoot;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StBoot;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            instr_q <= '0;
            opc_q   <= '0;
            opc4_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            opc_q   <= opc_d;
            opc4_q  <= opc4_d;
        end
    end

    assign inst_addr    = pc_q;
    assign out_valid    = valid_q;
    assign out_instr    = instr_q;
    assign out_pc       = opc_q;
    assign out_pc_plus4 = opc4_q;
    assign halted       = (state_q == StHalt);

`ifdef FETCH_PERF_EN
    logic        stall;
    logic [15:0] fetch_cnt_q;
    logic [15:0] stall_cnt_q;

    assign stall = (state_q == StFetch) && valid_q && !out_ready;

    // Saturating counters; redirects do not clear them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (capture && fetch_cnt_q != 16'hFFFF) begin
                fetch_cnt_q <= fetch_cnt_q + 16'd1;
            end
            if (stall && stall_cnt_q != 16'hFFFF) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`else
    // Counters compiled out.
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed boot/stall/redirect/halt/reset scenarios plus
// randomized ready/redirect traffic, checked by a scoreboard of expected fetch PCs.
module tb_fetch_unit;

    localparam int unsigned ROM_WORDS = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] inst_addr;
    logic [31:0] inst_data;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;
    logic        halted;
`ifdef FETCH_PERF_EN
    logic [15:0] perf_fetch_cnt;
    logic [15:0] perf_stall_cnt;
`endif

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    // ROM model: word content encodes its own address.
    assign inst_data = 32'hA000_0000 | inst_addr;

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .ROM_WORDS(ROM_WORDS)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .inst_addr      (inst_addr),
        .inst_data      (inst_data),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_pc_plus4   (out_pc_plus4),
        .halted         (halted)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    function automatic void check1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endfunction

    // Fetch stream from a (re)start address: sequential words up to the end of the ROM.
    function automatic void load_stream(input logic [31:0] start);
        logic [31:0] a;
        exp_q.delete();
        a = {start[31:2], 2'b00};
        while (a[31:2] < ROM_WORDS) begin
            exp_q.push_back(a);
            a = a + 32'd4;
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted instruction must be the next expected fetch.
    always @(negedge clk) begin
        logic [31:0] e;
        logic        ok;
        if (rst_n && out_valid && out_ready && !redirect_valid) begin
            check1("sb_expected_output", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("out_pc", out_pc, e);
                check("out_instr", out_instr, 32'hA000_0000 | e);
                check("out_pc_plus4", out_pc_plus4, e + 32'd4);
            end
        end
        if (rst_n && halted && !redirect_valid) begin
            // Halted: at most the already-buffered instruction may remain outstanding.
            ok = (exp_q.size() == 0) || (exp_q.size() == 1 && out_valid);
            check1("halt_nothing_pending", ok, 1'b1);
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got no end, expected end");
        $fatal(1);
    end

    initial begin
        bit seen;
        rst_n           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = '0;
        out_ready       = 1'b1;
        step();
        step();

        // Reset state
        check("rst_inst_addr", inst_addr, 32'h0);
        check1("rst_out_valid", out_valid, 1'b0);
        check("rst_out_instr", out_instr, 32'h0);
        check("rst_out_pc", out_pc, 32'h0);
        check("rst_out_pc_plus4", out_pc_plus4, 32'h0);
        check1("rst_halted", halted, 1'b0);
`ifdef FETCH_PERF_EN
        check({16'h0, perf_fetch_cnt} == 32'h0 ? "rst_perf_fetch" : "rst_perf_fetch",
              {16'h0, perf_fetch_cnt}, 32'h0);
`endif

        // Boot latency and streaming
        load_stream(32'h0);
        rst_n = 1'b1;
        step();
        check1("boot_edge1_valid", out_valid, 1'b0);
        step();
        check1("boot_edge2_valid", out_valid, 1'b1);
        check("boot_instr", out_instr, 32'hA000_0000);
        check("boot_pc", out_pc, 32'h0);
        step();
        check("stream_pc4", out_pc, 32'h4);
        step();
        check("stream_pc8", out_pc, 32'h8);

        // Stall for three cycles at out_pc=8
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_pc", out_pc, 32'h8);
            check("stall_instr", out_instr, 32'hA000_0008);
            check("stall_inst_addr", inst_addr, 32'hC);
        end
`ifdef FETCH_PERF_EN
        check("perf_stall_cnt", {16'h0, perf_stall_cnt}, 32'd3);
        check("perf_fetch_cnt", {16'h0, perf_fetch_cnt}, 32'd3);
`endif
        out_ready = 1'b1;
        step();
        check("after_stall_pc", out_pc, 32'hC);

        // Redirect to 0x13 while a handshake is in progress
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0013;
        load_stream(32'h0000_0013);
        step();
        redirect_valid = 1'b0;
        check1("redir_bubble_valid", out_valid, 1'b0);
        check("redir_inst_addr", inst_addr, 32'h10);
        step();
        check1("redir_valid", out_valid, 1'b1);
        check("redir_pc", out_pc, 32'h10);
        check("redir_instr", out_instr, 32'hA000_0010);

        // Stream to the end of the ROM and halt
        seen = 1'b0;
        for (int i = 0; i < 40 && !halted; i++) begin
            if (out_valid && out_pc == 32'h3C) seen = 1'b1;
            step();
        end
        check1("halt_last_delivered", seen, 1'b1);
        check1("halt_flag", halted, 1'b1);
        check("halt_inst_addr", inst_addr, 32'h40);
        check1("halt_drained", out_valid, 1'b0);
        for (int i = 0; i < 3; i++) step();
        check("halt_pc_held", inst_addr, 32'h40);
        check1("halt_no_capture", out_valid, 1'b0);
        redirect_valid  = 1'b1;
        redirect_target = 32'h0;
        load_stream(32'h0);
        step();
        redirect_valid = 1'b0;
        check1("unhalt_flag", halted, 1'b0);
        step();
        check1("unhalt_valid", out_valid, 1'b1);
        check("unhalt_pc", out_pc, 32'h0);

        // Asynchronous reset mid-stream
        step();
        step();
        check1("pre_areset_valid", out_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check1("areset_valid", out_valid, 1'b0);
        check("areset_inst_addr", inst_addr, 32'h0);
        check1("areset_halted", halted, 1'b0);
        load_stream(32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        check1("reboot_edge1_valid", out_valid, 1'b0);
        step();
        check1("reboot_edge2_valid", out_valid, 1'b1);
        check("reboot_pc", out_pc, 32'h0);

        // Redirect coinciding with an out-of-range PC and a pending output
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (inst_addr == 32'h40 && out_valid) seen = 1'b1;
            else step();
        end
        check1("simul_reached_end", seen, 1'b1);
        redirect_valid  = 1'b1;
        redirect_target = 32'h20;
        load_stream(32'h20);
        step();
        redirect_valid = 1'b0;
        check1("simul_halted", halted, 1'b0);
        check("simul_pc", inst_addr, 32'h20);
        check1("simul_flushed", out_valid, 1'b0);
        step();
        check("simul_next_pc", out_pc, 32'h20);

        // Randomized ready and redirect traffic
        for (int i = 0; i < 600; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) begin
                redirect_valid  = 1'b1;
                redirect_target = 32'($urandom_range(0, 79));
                load_stream(redirect_target);
            end else begin
                redirect_valid = 1'b0;
            end
            step();
        end

        // Drain the remaining stream; fetch must then sit halted
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) step();
        check("drain_queue_left", 32'(exp_q.size()), 32'h0);
        step();
        step();
        check1("final_halted", halted, 1'b1);
        check1("final_valid", out_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the single-cycle MIPS datapath, directly upstream of `inst_mem`. It owns the program counter and drives the instruction-memory address. It captures the returned instruction word into a one-entry output register, which feeds decode through a valid/ready handshake. It also supports redirects (branch/jump) and halts when the PC leaves the populated instruction ROM.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `ROM_WORDS`, default 16: number of populated instruction words. Word index ≥ `ROM_WORDS` is out of range.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `inst_addr`, out, 32: byte address to `inst_mem`. Equals the PC register, with no combinational path from inputs.
- `inst_data`, in, 32: instruction word from `inst_mem`. Combinational and valid in the same cycle as `inst_addr`.
- `redirect_valid`, in, 1: load a new PC this cycle.
- `redirect_target`, in, 32: new PC byte address; bits [1:0] are ignored.
- `out_valid`, out, 1: output register holds an instruction.
- `out_ready`, in, 1: decode accepts the instruction this cycle.
- `out_instr`, out, 32: captured instruction word.
- `out_pc`, out, 32: address the instruction was fetched from.
- `out_pc_plus4`, out, 32: `out_pc` + 4, modulo 2^32.
- `halted`, out, 1: fetch is stopped because the PC is out of range.
- `perf_fetch_cnt`, out, 16: present only with `FETCH_PERF_EN`.
- `perf_stall_cnt`, out, 16: present only with `FETCH_PERF_EN`.

## Operation
States: `BOOT`, `FETCH`, `HALT`.
- `BOOT`: entered on reset. No capture occurs. Moves to `FETCH` on the first edge after `rst_n` rises.
- `FETCH`: a capture occurs when `out_valid`=0, or when `out_valid`=1 and `out_ready`=1. On capture:
  - `out_instr`←`inst_data`, `out_pc`←PC, `out_pc_plus4`←PC+4, `out_valid`←1.
  - PC←PC+4, wrapping at 2^32.
- Holding: if `out_valid`=1 and `out_ready`=0, the PC and output register hold. This is a stall cycle.
- Handshake without capture: a handshake that completes without a capture clears `out_valid` (in `HALT`).
- Range check: evaluated on the PC before capture. If PC[31:2] ≥ `ROM_WORDS`:
  - No capture occurs and the state moves to `HALT`.
  - `halted`←1.
  - The output register still drains normally.
- `HALT`: no captures occur. The PC holds.
  - A redirect to an in-range target returns to `FETCH` and clears `halted`.
  - A redirect to an out-of-range target stays in `HALT`, with the PC updated to that target.
- Redirect in `FETCH` or `HALT`:
  - PC←{`redirect_target`[31:2], 2'b00}.
  - `out_valid`←0, flushing the buffered instruction; `out_ready` is ignored that cycle.
  - Any capture that would have happened this cycle is discarded.
- Redirect in `BOOT`: loads the PC and leaves `BOOT` as normal.
- Priority: reset > redirect > range check > capture/stall.

## Timing
- Reset values:
  - PC=`RESET_PC` and `inst_addr`=`RESET_PC`.
  - `out_valid`=0, `out_instr`=0, `out_pc`=0, `out_pc_plus4`=0, `halted`=0.
  - State=`BOOT`; perf counters =0.
- Asserting `rst_n`=0 mid-operation clears all of the above immediately, without waiting for a clock edge.
- Boot latency: edge 1 after reset release leaves `BOOT`; edge 2 captures the word at `RESET_PC`, so `out_valid`=1 after edge 2.
- Throughput: one instruction per cycle while `out_ready`=1.
- Redirect latency: the redirect edge sets the PC and flushes. The target instruction appears at `out_*` after the next edge, so the bubble is one cycle.
- Halt: `halted` rises on the edge where the out-of-range PC is seen. A pending output stays valid until it is accepted.

## Configuration
- `FETCH_PERF_EN` defined:
  - `perf_fetch_cnt` increments on every capture.
  - `perf_stall_cnt` increments on every cycle in `FETCH` with `out_valid`=1 and `out_ready`=0.
  - Both counters saturate at 16'hFFFF, reset to 0, and are not cleared by redirect.
- `FETCH_PERF_EN` undefined: both ports and all counter logic are absent; behaviour is otherwise identical.

## Test plan
The bench models the ROM as `inst_data` = 32'hA000_0000 | `inst_addr`, with default parameters.
- Boot and streaming: release reset, hold `out_ready`=1.
  - Response: `out_valid` first high after edge 2, with `out_instr`=32'hA000_0000 and `out_pc`=0.
  - Each subsequent cycle: `out_pc` 4, 8, 12…; `out_pc_plus4`=`out_pc`+4.
- Stall: hold `out_ready`=0 for 3 cycles while `out_pc`=8.
  - Response: `out_instr`/`out_pc` hold at 32'hA000_0008/8 and `inst_addr` holds at 12.
  - After `out_ready` rises, the next `out_pc`=12.
  - With `FETCH_PERF_EN`: `perf_stall_cnt`=3.
- Redirect: pulse `redirect_valid` with target 32'h0000_0013 while `out_valid`=1 and `out_ready`=1.
  - Response: `out_valid`=0 for one cycle, then `out_pc`=32'h10 and `out_instr`=32'hA000_0010.
- Halt: stream to PC 32'h3C.
  - Response: the instruction at 32'h3C is delivered, then `halted`=1 with the PC held at 32'h40 and no further captures.
  - Redirect to 0 clears `halted`; the next `out_pc`=0.
- Asynchronous reset mid-stream: drop `rst_n` between edges while `out_valid`=1.
  - Response: `out_valid`=0, `inst_addr`=0 and `halted`=0 immediately; boot latency repeats on release.
- Simultaneous events: redirect together with an out-of-range PC and a pending capture.
  - Response: the redirect wins, `halted` stays 0, and the PC equals the target.
